// File: rtl/uart_bus_bridge_if.sv
// Memory-bus connection between the UART bridge (master) and the
// arbiter/memory side (slave).
interface uart_bus_bridge_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] bus_ab;
  logic [7:0]  bus_do;
  logic        bus_we_n;
  logic [7:0]  bus_di;

  modport master (
    output bus_req, bus_ab, bus_do, bus_we_n,
    input  bus_gnt, bus_di
  );

  modport slave (
    input  bus_req, bus_ab, bus_do, bus_we_n,
    output bus_gnt, bus_di
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// Serial debug/loader master: decodes 'R'/'W' command frames received on rx
// into single-byte bus cycles and answers on tx with '.', '?' or read data.
module uart_bus_bridge #(
  parameter int clk_freq = 35000000,
  parameter int baud     = 115200,
  parameter int timeout  = 35000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  output logic              tx,
  uart_bus_bridge_if.master bus
);

  localparam int DIV   = clk_freq / baud;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int TMR_W = $clog2(timeout + 1);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(timeout);

  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] REPLY_OK  = 8'h2E;
  localparam logic [7:0] REPLY_BAD = 8'h3F;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [3:0] P_IDLE  = 4'd0;
  localparam logic [3:0] P_CMD   = 4'd1;
  localparam logic [3:0] P_AH    = 4'd2;
  localparam logic [3:0] P_AL    = 4'd3;
  localparam logic [3:0] P_DATA  = 4'd4;
  localparam logic [3:0] P_REQ   = 4'd5;
  localparam logic [3:0] P_ACC   = 4'd6;
  localparam logic [3:0] P_RD    = 4'd7;
  localparam logic [3:0] P_REPLY = 4'd8;

  logic             rx_p0, rx_p1, rx_p2;
  logic [1:0]       rx_st;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic             rx_vld;
  logic [7:0]       rx_shift;

  logic             tx_busy;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_left;
  logic [8:0]       tx_shift;
  logic             tx_load;

  logic [3:0]       p_st;
  logic             is_wr;
  logic [TMR_W-1:0] tmr;
  logic             tmr_exp;
  logic [7:0]       cmd_byte;
  logic [7:0]       reply_byte;

  assign tx_load = (p_st == P_REPLY) && !tx_busy;
  assign tmr_exp = (tmr == TMR_LIMIT);

  // rx synchroniser (p0, p1) plus one history stage (p2) for start-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Receiver bit timing: start re-check at half bit, then one sample per bit period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_vld <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (!rx_p1 && rx_p2) begin
            rx_st  <= RX_START;
            rx_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_st  <= RX_IDLE;
            rx_vld <= rx_p1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // Receive shift register, LSB first; holds the byte while rx_vld pulses
  always_ff @(posedge clk) begin
    if (rx_st == RX_DATA && rx_cnt == DIV_LAST) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  // Transmitter control: start bit on load, then 8 data bits and the stop bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_left <= '0;
    end else if (tx_load) begin
      tx      <= 1'b0;
      tx_busy <= 1'b1;
      tx_cnt  <= '0;
      tx_left <= 4'd9;
    end else if (tx_busy) begin
      if (tx_cnt == DIV_LAST) begin
        tx_cnt <= '0;
        if (tx_left == 4'd0) begin
          tx_busy <= 1'b0;
        end else begin
          tx      <= tx_shift[0];
          tx_left <= tx_left - 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CNT_ONE;
      end
    end
  end

  // Transmit shift register: data bits followed by the stop bit
  always_ff @(posedge clk) begin
    if (tx_load) begin
      tx_shift <= {1'b1, reply_byte};
    end else if (tx_busy && tx_cnt == DIV_LAST && tx_left != 4'd0) begin
      tx_shift <= {1'b1, tx_shift[8:1]};
    end
  end

  // Frame parser and bus-cycle sequencer; bytes are only taken in IDLE/AH/AL/DATA
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_st         <= P_IDLE;
      is_wr        <= 1'b0;
      tmr          <= '0;
      bus.bus_req  <= 1'b0;
      bus.bus_we_n <= 1'b1;
      bus.bus_ab   <= 16'h0000;
      bus.bus_do   <= 8'h00;
    end else begin
      case (p_st)
        P_IDLE: if (rx_vld) p_st <= P_CMD;
        P_CMD: begin
          tmr <= '0;
          if (cmd_byte == CMD_WR || cmd_byte == CMD_RD) begin
            is_wr <= (cmd_byte == CMD_WR);
            p_st  <= P_AH;
          end else begin
            p_st <= P_REPLY;
          end
        end
        P_AH: begin
          if (rx_vld) begin
            bus.bus_ab[15:8] <= rx_shift;
            tmr              <= '0;
            p_st             <= P_AL;
          end else if (tmr_exp) begin
            p_st <= P_IDLE;
          end else begin
            tmr <= tmr + TMR_ONE;
          end
        end
        P_AL: begin
          if (rx_vld) begin
            bus.bus_ab[7:0] <= rx_shift;
            tmr             <= '0;
            if (is_wr) begin
              p_st <= P_DATA;
            end else begin
              p_st        <= P_REQ;
              bus.bus_req <= 1'b1;
            end
          end else if (tmr_exp) begin
            p_st <= P_IDLE;
          end else begin
            tmr <= tmr + TMR_ONE;
          end
        end
        P_DATA: begin
          if (rx_vld) begin
            bus.bus_do  <= rx_shift;
            tmr         <= '0;
            p_st        <= P_REQ;
            bus.bus_req <= 1'b1;
          end else if (tmr_exp) begin
            p_st <= P_IDLE;
          end else begin
            tmr <= tmr + TMR_ONE;
          end
        end
        P_REQ: begin
          if (bus.bus_gnt) begin
            p_st         <= P_ACC;
            bus.bus_we_n <= !is_wr;
          end
        end
        P_ACC: begin
          bus.bus_we_n <= 1'b1;
          if (is_wr) begin
            bus.bus_req <= 1'b0;
            p_st        <= P_REPLY;
          end else begin
            p_st <= P_RD;
          end
        end
        P_RD: begin
          bus.bus_req <= 1'b0;
          p_st        <= P_REPLY;
        end
        P_REPLY: if (!tx_busy) p_st <= P_IDLE;
        default: p_st <= P_IDLE;
      endcase
    end
  end

  // Command byte latch and one-deep reply buffer
  always_ff @(posedge clk) begin
    if (p_st == P_IDLE && rx_vld) cmd_byte <= rx_shift;
    if (p_st == P_CMD) reply_byte <= REPLY_BAD;
    else if (p_st == P_ACC && is_wr) reply_byte <= REPLY_OK;
    else if (p_st == P_RD) reply_byte <= bus.bus_di;
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge at DIV=10: table of command frames plus
// hand-written sequences for grant stall, timeout, framing error, glitch and reset.
module tb_uart_bus_bridge;
  localparam int DIV     = 10;
  localparam int TIMEOUT = 300;

  logic clk;
  logic reset_n;
  logic rx_line;
  logic tx;

  uart_bus_bridge_if bif();

  uart_bus_bridge #(
    .clk_freq(1000000),
    .baud    (100000),
    .timeout (TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rx     (rx_line),
    .tx     (tx),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0]  pmem [65536];
  logic [7:0]  wmem [65536];
  bit          wval [65536];
  int          wr_cnt  = 0;
  int          req_cyc = 0;
  logic [15:0] last_ab;
  logic [7:0]  last_do;
  logic [7:0]  rx_q [$];

  // Bus monitor / write side of the memory model
  always @(negedge clk) begin
    if (bif.bus_req) req_cyc++;
    if (!bif.bus_we_n) begin
      wr_cnt++;
      last_ab = bif.bus_ab;
      last_do = bif.bus_do;
      wmem[bif.bus_ab] = bif.bus_do;
      wval[bif.bus_ab] = 1'b1;
    end
  end

  // Registered read port: data follows the address by one clock
  always @(posedge clk) bif.bus_di <= wval[bif.bus_ab] ? wmem[bif.bus_ab] : pmem[bif.bus_ab];

  // UART decoder on tx
  initial begin
    logic [7:0] mb;
    forever begin
      @(negedge tx);
      repeat (DIV / 2) @(posedge clk);
      #1;
      if (tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1;
          mb[i] = tx;
        end
        repeat (DIV) @(posedge clk);
        #1;
        rx_q.push_back(mb);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx_line = stop;
    repeat (DIV) @(negedge clk);
    rx_line = 1'b1;
    if (!stop) repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] fb [4];
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
    for (int i = 0; i < n; i++) send_byte(fb[i], 1'b1);
  endtask

  task automatic wait_reply(output int b);
    int i;
    b = -1;
    i = 0;
    while (b < 0 && i < 3000) begin
      @(posedge clk);
      if (rx_q.size() != 0) b = int'(rx_q.pop_front());
      i++;
    end
  endtask

  task automatic wait_req(output int seen);
    int i;
    seen = 0;
    i = 0;
    while (seen == 0 && i < 1000) begin
      @(negedge clk);
      if (bif.bus_req) seen = 1;
      i++;
    end
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  b0, b1, b2, b3;
    int          exp_reply;
    int          exp_wr;
    int          exp_req;
    logic [15:0] exp_ab;
    logic [7:0]  exp_do;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int r, w0, q0, seen, lowcnt;

    vecs[0] = '{"wr1234", 4, 8'h57, 8'h12, 8'h34, 8'hA5, 'h2E, 1, 2, 16'h1234, 8'hA5};
    vecs[1] = '{"rd0fff", 3, 8'h52, 8'h0F, 8'hFF, 8'h00, 'h3C, 0, 3, 16'h0000, 8'h00};
    vecs[2] = '{"badcmd", 1, 8'h41, 8'h00, 8'h00, 8'h00, 'h3F, 0, 0, 16'h0000, 8'h00};
    vecs[3] = '{"wrbeef", 4, 8'h57, 8'hBE, 8'hEF, 8'h5A, 'h2E, 1, 2, 16'hBEEF, 8'h5A};
    vecs[4] = '{"rdbeef", 3, 8'h52, 8'hBE, 8'hEF, 8'h00, 'h5A, 0, 3, 16'h0000, 8'h00};

    pmem[16'h0FFF] = 8'h3C;
    pmem[16'h0010] = 8'h5A;
    pmem[16'h0000] = 8'h77;

    reset_n     = 1'b0;
    rx_line     = 1'b1;
    bif.bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_req", int'(bif.bus_req), 0);
    check("rst_ab", int'(bif.bus_ab), 'h0000);
    check("rst_do", int'(bif.bus_do), 'h00);
    check("rst_we_n", int'(bif.bus_we_n), 1);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      w0 = wr_cnt;
      q0 = req_cyc;
      send_frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, vecs[v].n);
      wait_reply(r);
      check({vecs[v].name, "_reply"}, r, vecs[v].exp_reply);
      check({vecs[v].name, "_wr"}, wr_cnt - w0, vecs[v].exp_wr);
      check({vecs[v].name, "_req"}, req_cyc - q0, vecs[v].exp_req);
      if (vecs[v].exp_wr != 0) begin
        check({vecs[v].name, "_ab"}, int'(last_ab), int'(vecs[v].exp_ab));
        check({vecs[v].name, "_do"}, int'(last_do), int'(vecs[v].exp_do));
      end
      repeat (2 * DIV) @(negedge clk);
    end

    // Grant withheld: request must stay up with no cycle and no reply
    bif.bus_gnt = 1'b0;
    w0 = wr_cnt;
    send_frame(8'h52, 8'h00, 8'h10, 8'h00, 3);
    wait_req(seen);
    check("gnt0_req_rise", seen, 1);
    lowcnt = 0;
    repeat (500) begin
      @(negedge clk);
      if (!bif.bus_req) lowcnt++;
    end
    check("gnt0_req_held", lowcnt, 0);
    check("gnt0_no_reply", rx_q.size(), 0);
    bif.bus_gnt = 1'b1;
    wait_reply(r);
    check("gnt0_reply", r, 'h5A);
    check("gnt0_req_drop", int'(bif.bus_req), 0);
    check("gnt0_wr", wr_cnt - w0, 0);

    // Inter-byte timeout discards the partial write frame
    repeat (2 * DIV) @(negedge clk);
    w0 = wr_cnt;
    send_frame(8'h57, 8'h00, 8'h00, 8'h00, 2);
    repeat (TIMEOUT + 50) @(negedge clk);
    send_frame(8'h52, 8'h00, 8'h00, 8'h00, 3);
    wait_reply(r);
    check("tmo_reply", r, 'h77);
    check("tmo_wr", wr_cnt - w0, 0);

    // Framing error inside a write frame: the bad byte is ignored
    repeat (2 * DIV) @(negedge clk);
    w0 = wr_cnt;
    send_frame(8'h57, 8'h00, 8'h00, 8'h00, 2);
    send_byte(8'h20, 1'b0);
    send_frame(8'h30, 8'h99, 8'h00, 8'h00, 2);
    wait_reply(r);
    check("ferr_reply", r, 'h2E);
    check("ferr_wr", wr_cnt - w0, 1);
    check("ferr_ab", int'(last_ab), 'h0030);
    check("ferr_do", int'(last_do), 'h99);

    // Short low glitch on rx must not produce a byte
    repeat (2 * DIV) @(negedge clk);
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_no_reply", rx_q.size(), 0);
    send_frame(8'h52, 8'h0F, 8'hFF, 8'h00, 3);
    wait_reply(r);
    check("glitch_then_read", r, 'h3C);

    // Reset while waiting for grant drops the request and cancels the write
    repeat (2 * DIV) @(negedge clk);
    bif.bus_gnt = 1'b0;
    w0 = wr_cnt;
    send_frame(8'h57, 8'h00, 8'h40, 8'h66, 4);
    wait_req(seen);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstreq_req", int'(bif.bus_req), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bif.bus_gnt = 1'b1;
    repeat (300) @(negedge clk);
    check("rstreq_no_wr", wr_cnt - w0, 0);

    // Reset during the reply start bit forces tx high at once
    send_frame(8'h52, 8'h0F, 8'hFF, 8'h00, 3);
    seen = 0;
    for (int i = 0; i < 2000 && seen == 0; i++) begin
      @(negedge clk);
      if (tx == 1'b0) seen = 1;
    end
    check("rsttx_start", seen, 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rsttx_tx", int'(tx), 1);
    check("rsttx_req", int'(bif.bus_req), 0);
    check("rsttx_we_n", int'(bif.bus_we_n), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    rx_q.delete();

    w0 = wr_cnt;
    send_frame(8'h57, 8'h00, 8'h00, 8'h11, 4);
    wait_reply(r);
    check("post_rst_reply", r, 'h2E);
    check("post_rst_wr", wr_cnt - w0, 1);
    check("post_rst_ab", int'(last_ab), 'h0000);
    check("post_rst_do", int'(last_do), 'h11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
